// File: rtl/sbox_share_scheduler_if.sv
// Request/response bundle between the round controller, key expander and the shared SBox scheduler.
// master = requester side, slave = scheduler side.
interface sbox_share_scheduler_if;
    logic         sb_req_valid;
    logic         sb_req_ready;
    logic [127:0] sb_req_state;
    logic         sb_rsp_valid;
    logic [127:0] sb_rsp_state;
    logic         kw_req_valid;
    logic         kw_req_ready;
    logic [31:0]  kw_req_word;
    logic         kw_rsp_valid;
    logic [31:0]  kw_rsp_word;

    modport master (
        output sb_req_valid, sb_req_state, kw_req_valid, kw_req_word,
        input  sb_req_ready, sb_rsp_valid, sb_rsp_state,
        input  kw_req_ready, kw_rsp_valid, kw_rsp_word
    );

    modport slave (
        input  sb_req_valid, sb_req_state, kw_req_valid, kw_req_word,
        output sb_req_ready, sb_rsp_valid, sb_rsp_state,
        output kw_req_ready, kw_rsp_valid, kw_rsp_word
    );
endinterface

// File: rtl/sbox_share_scheduler.sv
// Time-shares one 4-wide SBox bank between SubBytes (4 lookups) and SubWord (1 lookup) requests.
// Requests are captured on accept, so requester inputs may change freely while a job runs.
module sbox_share_scheduler #(
    parameter bit KEY_PRIORITY = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    sbox_share_scheduler_if.slave        bus,
    output logic                         sbox_valid,
    output logic [31:0]                  sbox_addr,
    input  logic [31:0]                  sbox_dout,
    output logic                         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        KEY  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [1:0]   r_cnt;
    logic [127:0] r_sb_cap;
    logic [31:0]  r_kw_cap;
    logic [127:0] r_sb_rsp;
    logic [31:0]  r_kw_rsp;
    logic         r_sb_rsp_valid;
    logic         r_kw_rsp_valid;
    logic         r_last_kw;
    logic         w_grant_sb;
    logic         w_grant_kw;
    logic [3:0]   w_slice_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Tie-break: fixed KW priority, or hand the grant to whoever did not win last time.
    always_comb begin
        w_state_next = r_state;
        w_grant_sb   = 1'b0;
        w_grant_kw   = 1'b0;
        sbox_valid   = 1'b0;
        sbox_addr    = '0;
        case (r_state)
            IDLE: begin
                if (bus.sb_req_valid && (!bus.kw_req_valid || (!KEY_PRIORITY && r_last_kw))) begin
                    w_grant_sb   = 1'b1;
                    w_state_next = SUB;
                end else if (bus.kw_req_valid) begin
                    w_grant_kw   = 1'b1;
                    w_state_next = KEY;
                end
            end
            SUB: begin
                sbox_valid = 1'b1;
                sbox_addr  = r_sb_cap[{r_cnt, 5'd0} +: 32];
                if (r_cnt == 2'd3) begin
                    w_state_next = IDLE;
                end
            end
            KEY: begin
                sbox_valid   = 1'b1;
                sbox_addr    = r_kw_cap;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice_we
            assign w_slice_we[gi] = (r_state == SUB) && (r_cnt == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= 2'd0;
            r_sb_cap       <= '0;
            r_kw_cap       <= '0;
            r_sb_rsp       <= '0;
            r_kw_rsp       <= '0;
            r_sb_rsp_valid <= 1'b0;
            r_kw_rsp_valid <= 1'b0;
            r_last_kw      <= 1'b0;
        end else begin
            r_sb_rsp_valid <= 1'b0;
            r_kw_rsp_valid <= 1'b0;
            if (w_grant_sb) begin
                r_sb_cap  <= bus.sb_req_state;
                r_cnt     <= 2'd0;
                r_last_kw <= 1'b0;
            end
            if (w_grant_kw) begin
                r_kw_cap  <= bus.kw_req_word;
                r_last_kw <= 1'b1;
            end
            // Counter wraps 3 -> 0 on the final lookup, leaving it ready for the next job.
            if (r_state == SUB) begin
                r_cnt <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_sb_rsp_valid <= 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (w_slice_we[i]) begin
                    r_sb_rsp[32*i +: 32] <= sbox_dout;
                end
            end
            if (r_state == KEY) begin
                r_kw_rsp       <= sbox_dout;
                r_kw_rsp_valid <= 1'b1;
            end
        end
    end

    assign busy             = (r_state != IDLE);
    assign bus.sb_req_ready = w_grant_sb;
    assign bus.kw_req_ready = w_grant_kw;
    assign bus.sb_rsp_valid = r_sb_rsp_valid;
    assign bus.sb_rsp_state = r_sb_rsp;
    assign bus.kw_rsp_valid = r_kw_rsp_valid;
    assign bus.kw_rsp_word  = r_kw_rsp;

endmodule

// File: tb/tb_sbox_share_scheduler.sv
// Bench: two schedulers (KEY_PRIORITY=1 as dut 0, KEY_PRIORITY=0 as dut 1) fed identical stimulus,
// each checked every cycle against a timing/data reference model built on a computed AES SBox.
module tb_sbox_share_scheduler;

    localparam logic [127:0] V1   = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] V1_X = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;
    localparam logic [31:0]  W2   = 32'h09cf4f3c;
    localparam logic [31:0]  W2_X = 32'h018a84eb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         sb_valid;
    logic         kw_valid;
    logic [127:0] sb_state;
    logic [31:0]  kw_word;

    logic [1:0]         sv;
    logic [1:0]         bsy;
    logic [1:0][31:0]   addr;
    logic [1:0][31:0]   dout;
    logic [1:0]         o_sb_rdy;
    logic [1:0]         o_kw_rdy;
    logic [1:0]         o_sb_v;
    logic [1:0]         o_kw_v;
    logic [1:0][127:0]  o_sb_st;
    logic [1:0][31:0]   o_kw_w;

    sbox_share_scheduler_if if_p1 ();
    sbox_share_scheduler_if if_p0 ();

    assign if_p1.sb_req_valid = sb_valid;
    assign if_p1.sb_req_state = sb_state;
    assign if_p1.kw_req_valid = kw_valid;
    assign if_p1.kw_req_word  = kw_word;
    assign if_p0.sb_req_valid = sb_valid;
    assign if_p0.sb_req_state = sb_state;
    assign if_p0.kw_req_valid = kw_valid;
    assign if_p0.kw_req_word  = kw_word;

    assign o_sb_rdy[0] = if_p1.sb_req_ready;
    assign o_kw_rdy[0] = if_p1.kw_req_ready;
    assign o_sb_v[0]   = if_p1.sb_rsp_valid;
    assign o_kw_v[0]   = if_p1.kw_rsp_valid;
    assign o_sb_st[0]  = if_p1.sb_rsp_state;
    assign o_kw_w[0]   = if_p1.kw_rsp_word;
    assign o_sb_rdy[1] = if_p0.sb_req_ready;
    assign o_kw_rdy[1] = if_p0.kw_req_ready;
    assign o_sb_v[1]   = if_p0.sb_rsp_valid;
    assign o_kw_v[1]   = if_p0.kw_rsp_valid;
    assign o_sb_st[1]  = if_p0.sb_rsp_state;
    assign o_kw_w[1]   = if_p0.kw_rsp_word;

    sbox_share_scheduler #(.KEY_PRIORITY(1'b1)) dut_p1 (
        .clk        (clk),
        .rst        (rst),
        .bus        (if_p1.slave),
        .sbox_valid (sv[0]),
        .sbox_addr  (addr[0]),
        .sbox_dout  (dout[0]),
        .busy       (bsy[0])
    );

    sbox_share_scheduler #(.KEY_PRIORITY(1'b0)) dut_p0 (
        .clk        (clk),
        .rst        (rst),
        .bus        (if_p0.slave),
        .sbox_valid (sv[1]),
        .sbox_addr  (addr[1]),
        .sbox_dout  (dout[1]),
        .busy       (bsy[1])
    );

    // AES SBox from first principles: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] sq, inv, r, s;
        sq = x; inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        r = inv; s = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] o;
        for (int j = 0; j < 4; j++) o[8*j +: 8] = sbox_byte(w[8*j +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] st);
        logic [127:0] o;
        for (int j = 0; j < 16; j++) o[8*j +: 8] = sbox_byte(st[8*j +: 8]);
        return o;
    endfunction

    assign dout[0] = sub_word(addr[0]);
    assign dout[1] = sub_word(addr[1]);

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // Reference model: job windows and expected data per DUT, in absolute cycle numbers.
    int           free_at   [2];
    bit           last_kw   [2];
    int           sb_due    [2];
    int           kw_due    [2];
    int           sub_start [2];
    logic [127:0] sb_cap    [2];
    logic [127:0] sb_exp    [2];
    logic [127:0] sb_hold   [2];
    logic [31:0]  kw_cap    [2];
    logic [31:0]  kw_exp    [2];
    logic [31:0]  kw_hold   [2];

    task automatic check(input string tag, input int d, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, d, cyc, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        free_at[d]   = cyc + 1;
        last_kw[d]   = 1'b0;
        sb_due[d]    = -100;
        kw_due[d]    = -100;
        sub_start[d] = -100;
        sb_hold[d]   = '0;
        kw_hold[d]   = '0;
    endtask

    task automatic model_cycle(input int d);
        bit idle, in_sub, g_sb, g_kw, kp;
        logic [31:0] exp_addr;
        kp     = (d == 0);
        idle   = (cyc >= free_at[d]);
        in_sub = !idle && (cyc >= sub_start[d]) && (cyc < sub_start[d] + 4);
        if (cyc == sb_due[d]) sb_hold[d] = sb_exp[d];
        if (cyc == kw_due[d]) kw_hold[d] = kw_exp[d];
        check("sb_rsp_valid", d, o_sb_v[d], (cyc == sb_due[d]));
        check("kw_rsp_valid", d, o_kw_v[d], (cyc == kw_due[d]));
        if (!in_sub) check("sb_rsp_state", d, o_sb_st[d], sb_hold[d]);
        check("kw_rsp_word", d, o_kw_w[d], kw_hold[d]);
        check("busy", d, bsy[d], !idle);
        check("sbox_valid", d, sv[d], !idle);
        if (idle)        exp_addr = 32'h0;
        else if (in_sub) exp_addr = sb_cap[d][32*(cyc - sub_start[d]) +: 32];
        else             exp_addr = kw_cap[d];
        check("sbox_addr", d, addr[d], exp_addr);
        g_sb = idle && sb_valid && (!kw_valid || (!kp && last_kw[d]));
        g_kw = idle && kw_valid && !g_sb;
        check("sb_req_ready", d, o_sb_rdy[d], g_sb);
        check("kw_req_ready", d, o_kw_rdy[d], g_kw);
        if (g_sb) begin
            sb_cap[d]    = sb_state;
            sb_exp[d]    = sub_bytes(sb_state);
            sub_start[d] = cyc + 1;
            sb_due[d]    = cyc + 5;
            free_at[d]   = cyc + 5;
            last_kw[d]   = 1'b0;
        end
        if (g_kw) begin
            kw_cap[d]  = kw_word;
            kw_exp[d]  = sub_word(kw_word);
            kw_due[d]  = cyc + 2;
            free_at[d] = cyc + 2;
            last_kw[d] = 1'b1;
        end
    endtask

    task automatic tick();
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst) model_reset(d);
            else     model_cycle(d);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int n_sb, n_kw, n_acc, prev, g;
        rst = 1'b1; sb_valid = 1'b0; kw_valid = 1'b0; sb_state = '0; kw_word = '0;
        #1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Test 1: single SubBytes, response at +5.
        sb_valid = 1'b1; sb_state = V1;
        tick();
        sb_valid = 1'b0; sb_state = rnd128();
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) begin
                check("t1_sb_data", 0, o_sb_st[0], V1_X);
                check("t1_sb_data", 1, o_sb_st[1], V1_X);
            end
            tick();
        end

        // Test 2: single SubWord, response at +2.
        kw_valid = 1'b1; kw_word = W2;
        tick();
        kw_valid = 1'b0; kw_word = $urandom();
        tick();
        check("t2_kw_data", 0, o_kw_w[0], W2_X);
        check("t2_kw_data", 1, o_kw_w[1], W2_X);
        tick();

        // Test 3: simultaneous requests, KW first on the priority instance.
        sb_valid = 1'b1; kw_valid = 1'b1; sb_state = V1; kw_word = W2;
        for (int k = 0; k <= 8; k++) begin
            if (k == 1) kw_valid = 1'b0;
            if (k == 3) sb_valid = 1'b0;
            #1;
            check("t3_sb_ready", 0, o_sb_rdy[0], (k == 2));
            check("t3_kw_rsp", 0, o_kw_v[0], (k == 2));
            check("t3_sb_rsp", 0, o_sb_v[0], (k == 7));
            tick();
        end

        // Test 4: both held valid; round-robin instance must alternate starting with KW.
        n_sb = 0; n_kw = 0; prev = -1;
        for (int k = 0; k < 20; k++) begin
            sb_valid = 1'b1; kw_valid = 1'b1; sb_state = rnd128(); kw_word = $urandom();
            #1;
            g = o_kw_rdy[1] ? 1 : (o_sb_rdy[1] ? 0 : -1);
            if (g >= 0) begin
                check("t4_alternate", 1, g, (prev < 0) ? 1 : 1 - prev);
                prev = g;
                if (g == 1) n_kw++; else n_sb++;
            end
            tick();
        end
        check("t4_no_starve", 1, (n_sb >= 2) && (n_kw >= 2), 1);
        sb_valid = 1'b0; kw_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();

        // Test 5: reset during SUB with cnt=2 aborts silently.
        sb_valid = 1'b1; sb_state = rnd128();
        tick();
        sb_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("t5_busy", d, bsy[d], 0);
            check("t5_sbox_addr", d, addr[d], 0);
            check("t5_sb_state", d, o_sb_st[d], 0);
        end
        tick();
        sb_valid = 1'b1; sb_state = V1;
        tick();
        sb_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) begin
                check("t5_sb_data", 0, o_sb_st[0], V1_X);
                check("t5_sb_data", 1, o_sb_st[1], V1_X);
            end
            tick();
        end

        // Test 6: SB valid held with fresh random state every cycle -> one accept per 5 cycles.
        n_acc = 0;
        for (int k = 0; k < 40; k++) begin
            sb_valid = 1'b1; sb_state = rnd128();
            #1;
            if (o_sb_rdy[1]) n_acc++;
            tick();
        end
        check("t6_accepts", 1, n_acc, 8);
        sb_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
